axi_read_arbiter: RTL
=====================

Name: axi_read_arbiter

Overview:
Two-master to one-slave arbiter for the AXI read path in front of axi_slave. Instruction fetch (index 0) and data load (index 1) share the single read channel. Arbitration is round-robin and per-burst: a grant is held from the AR handshake through the RLAST beat. A beat counter checks that the slave's RLAST matches ARLEN.

Parameters:
ADDR_WIDTH, 32, address width
READ_CHANNEL_WIDTH, 4, RDATA bits per beat
READ_BURST_LEN, 8, ARLEN width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
m_ARADDR  in  2*ADDR_WIDTH  packed, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_ARVALID  in  2  per-master AR valid
m_ARLEN  in  2*READ_BURST_LEN  packed ARLEN
m_ARSIZE  in  6  packed ARSIZE
m_ARBURST  in  4  packed ARBURST
m_ARREADY  out  2  per-master AR ready
m_RVALID  out  2  per-master R valid
m_RDATA  out  2*READ_CHANNEL_WIDTH  packed RDATA
m_RLAST  out  2  per-master RLAST
m_RRESP  out  4  packed RRESP
m_RREADY  in  2  per-master R ready
s_ARADDR  out  ADDR_WIDTH  to slave
s_ARVALID  out  1  to slave
s_ARLEN  out  READ_BURST_LEN  to slave
s_ARSIZE  out  3  to slave
s_ARBURST  out  2  to slave
s_ARREADY  in  1  from slave
s_RVALID  in  1  from slave
s_RDATA  in  READ_CHANNEL_WIDTH  from slave
s_RLAST  in  1  from slave
s_RRESP  in  2  from slave
s_RREADY  out  1  to slave
grant  out  1  current owner index, valid when busy=1
busy  out  1  burst in progress (state != IDLE)
prot_err  out  1  sticky RLAST/ARLEN mismatch flag

Behaviour:
- States: IDLE, ADDR, DATA. Registers: state, grant, prio (favoured master), beat_cnt (READ_BURST_LEN bits), len_q, prot_err.
- Reset (rst_n=0 at posedge): state=IDLE, grant=0, prio=0, beat_cnt=0, prot_err=0. Reset mid-burst aborts silently; slave reset is the system's responsibility.
- All outputs are decoded from state and grant:
  - s_ARVALID=1 only in ADDR.
  - s_RREADY is nonzero only in DATA.
  - m_ARREADY and m_RVALID are 0 in IDLE.
  - The non-granted master always sees ARREADY=0 and RVALID=0.
- IDLE:
  - If exactly one m_ARVALID bit is set, grant that master.
  - If both are set, grant prio.
  - Latch len_q from the winner's ARLEN, clear beat_cnt, go to ADDR.
  - Arbitration costs 1 cycle: s_ARVALID rises one cycle after m_ARVALID at the earliest.
- ADDR:
  - s_AR* = granted master's AR fields (mux on grant).
  - m_ARREADY[grant] = s_ARREADY, combinational.
  - On s_ARVALID & s_ARREADY, go to DATA.
  - The grant holds even if the master drops ARVALID (a protocol violation); not checked.
- DATA:
  - s_RREADY = m_RREADY[grant].
  - m_RVALID[grant], m_RDATA, m_RLAST and m_RRESP come from the slave.
  - Non-granted data lanes are driven 0.
  - On each beat (s_RVALID & s_RREADY), beat_cnt++.
  - On the beat with s_RLAST: go to IDLE and set prio = ~grant. Set prot_err if beat_cnt != len_q (ARLEN+1 beats expected).
  - Also set prot_err if beat_cnt == len_q on a beat without RLAST. In that case the state stays in DATA until RLAST arrives.
- Back-to-back: from RLAST to the next s_ARVALID is 2 cycles minimum (IDLE arbitration, then ADDR). A new request is never accepted in the RLAST cycle.
- prot_err is cleared only by reset.
- beat_cnt wraps modulo 2^READ_BURST_LEN. ARLEN = 255 with 256 beats is legal: len_q=255, and beat_cnt reads 255 when the last beat occurs.

Decomposition:
- Shared package axi_pkg holds:
  - the RRESP codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the ARBURST codes FIXED=2'b00, INCR=2'b01, WRAP=2'b10;
  - the state encoding localparams IDLE=2'd0, ADDR=2'd1, DATA=2'd2.
- One natural sub-module is rr_arb2: a 2-request round-robin picker with inputs req[1:0] and prio, output gnt_idx. It is purely combinational; prio is updated in the parent.

Test Plan:
- Single request: m_ARVALID=2'b01, ARADDR=0x100, ARLEN=3, s_ARREADY=1.
  -> s_ARVALID at cycle 1, s_ARADDR=0x100, m_ARREADY=2'b01 that cycle.
  -> 4 beats routed to master 0, m_RVALID[1]=0 throughout, prot_err=0, busy=0 the cycle after RLAST.
- Contention: both ARVALID from reset.
  -> master 0 granted first; after its RLAST, master 1 granted.
  -> If master 0 re-requests, it is served after master 1 (alternation 0,1,0).
- Backpressure: m_RREADY[grant] low for 3 cycles mid-burst.
  -> s_RREADY low for those cycles, beat_cnt holds, no beat lost or duplicated.
- Early RLAST: ARLEN=3, slave asserts RLAST on beat 2 -> prot_err=1 and stays 1, state returns to IDLE.
- Reset in DATA: rst_n=0 for one cycle after beat 1 -> busy=0, grant=0, all valids/readies 0 the next cycle; a fresh request proceeds normally.
- ARLEN=0, slave asserts RLAST on the first beat -> single-beat burst, prot_err stays 0.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-path codes and the arbiter state encoding.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker; the favoured index is owned by the parent.
module rr_arb2
  import axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_idx
);

  // Contention goes to the favoured master, otherwise to whoever asks.
  always_comb begin
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = prio;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter: round-robin, grant held from AR handshake to RLAST,
// with a sticky flag when the slave's RLAST disagrees with ARLEN.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH         = 32,
  parameter int READ_CHANNEL_WIDTH = 4,
  parameter int READ_BURST_LEN     = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [2*ADDR_WIDTH-1:0]         m_ARADDR,
  input  logic [1:0]                      m_ARVALID,
  input  logic [2*READ_BURST_LEN-1:0]     m_ARLEN,
  input  logic [5:0]                      m_ARSIZE,
  input  logic [3:0]                      m_ARBURST,
  output logic [1:0]                      m_ARREADY,
  output logic [1:0]                      m_RVALID,
  output logic [2*READ_CHANNEL_WIDTH-1:0] m_RDATA,
  output logic [1:0]                      m_RLAST,
  output logic [3:0]                      m_RRESP,
  input  logic [1:0]                      m_RREADY,
  output logic [ADDR_WIDTH-1:0]           s_ARADDR,
  output logic                            s_ARVALID,
  output logic [READ_BURST_LEN-1:0]       s_ARLEN,
  output logic [2:0]                      s_ARSIZE,
  output logic [1:0]                      s_ARBURST,
  input  logic                            s_ARREADY,
  input  logic                            s_RVALID,
  input  logic [READ_CHANNEL_WIDTH-1:0]   s_RDATA,
  input  logic                            s_RLAST,
  input  logic [1:0]                      s_RRESP,
  output logic                            s_RREADY,
  output logic                            grant,
  output logic                            busy,
  output logic                            prot_err
);

  state_e                    r_state;
  state_e                    w_next_state;
  logic                      r_grant;
  logic                      r_prio;
  logic [READ_BURST_LEN-1:0] r_beat_cnt;
  logic [READ_BURST_LEN-1:0] r_len_q;
  logic                      r_prot_err;
  logic                      w_gnt_idx;
  logic                      w_beat;

  rr_arb2 u_rr_arb2 (
    .req     (m_ARVALID),
    .prio    (r_prio),
    .gnt_idx (w_gnt_idx)
  );

  assign w_beat = (r_state == DATA) && s_RVALID && s_RREADY;

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (|m_ARVALID) w_next_state = ADDR; else w_next_state = IDLE;
      ADDR:    if (s_ARREADY) w_next_state = DATA; else w_next_state = ADDR;
      DATA:    if (w_beat && s_RLAST) w_next_state = IDLE; else w_next_state = DATA;
      default: w_next_state = IDLE;
    endcase
  end

  // State, ownership and beat accounting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= 1'b0;
      r_prio     <= 1'b0;
      r_beat_cnt <= '0;
      r_len_q    <= '0;
      r_prot_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && (|m_ARVALID)) begin
        r_grant    <= w_gnt_idx;
        r_len_q    <= w_gnt_idx ? m_ARLEN[2*READ_BURST_LEN-1:READ_BURST_LEN]
                                : m_ARLEN[READ_BURST_LEN-1:0];
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + READ_BURST_LEN'(1);
        if (s_RLAST) begin
          r_prio <= ~r_grant;
          if (r_beat_cnt != r_len_q) r_prot_err <= 1'b1;
        end else if (r_beat_cnt == r_len_q) begin
          // Final expected beat arrived without RLAST: keep draining until it shows.
          r_prot_err <= 1'b1;
        end
      end
    end
  end

  // Channel steering decoded from state and current owner.
  always_comb begin
    s_ARADDR  = r_grant ? m_ARADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_ARADDR[ADDR_WIDTH-1:0];
    s_ARLEN   = r_grant ? m_ARLEN[2*READ_BURST_LEN-1:READ_BURST_LEN] : m_ARLEN[READ_BURST_LEN-1:0];
    s_ARSIZE  = r_grant ? m_ARSIZE[5:3] : m_ARSIZE[2:0];
    s_ARBURST = r_grant ? m_ARBURST[3:2] : m_ARBURST[1:0];
    s_ARVALID = 1'b0;
    s_RREADY  = 1'b0;
    m_ARREADY = 2'b00;
    m_RVALID  = 2'b00;
    m_RDATA   = '0;
    m_RLAST   = 2'b00;
    m_RRESP   = 4'b0000;
    case (r_state)
      ADDR: begin
        s_ARVALID          = 1'b1;
        m_ARREADY[r_grant] = s_ARREADY;
      end
      DATA: begin
        s_RREADY          = m_RREADY[r_grant];
        m_RVALID[r_grant] = s_RVALID;
        m_RLAST[r_grant]  = s_RLAST;
        if (r_grant) begin
          m_RDATA[2*READ_CHANNEL_WIDTH-1:READ_CHANNEL_WIDTH] = s_RDATA;
          m_RRESP[3:2] = s_RRESP;
        end else begin
          m_RDATA[READ_CHANNEL_WIDTH-1:0] = s_RDATA;
          m_RRESP[1:0] = s_RRESP;
        end
      end
      default: begin
        s_ARVALID = 1'b0;
      end
    endcase
  end

  assign grant    = r_grant;
  assign busy     = (r_state != IDLE);
  assign prot_err = r_prot_err;

endmodule
